// File: rtl/mem_wb_writeback.sv
// MEM/WB pipeline register and write-back driver: captures MEM results,
// extracts/extends load data, drives the register-file write port and
// counts retired instructions.
// Ports:
//   clk, rst_n, stall, flush       : clock, async active-low reset, control
//   mem_*                          : MEM-stage entry fields
//   regWrite, writeReg, writeData  : register-file write port
//   wb_valid, misaligned, retired  : WB status and retired counter
module mem_wb_writeback #(
    parameter int CNT_WIDTH  = 32,
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 stall,
    input  logic                 flush,
    input  logic                 mem_valid,
    input  logic                 mem_regWrite,
    input  logic                 mem_memToReg,
    input  logic                 mem_link,
    input  logic [1:0]           mem_loadSize,
    input  logic                 mem_loadUnsigned,
    input  logic [4:0]           mem_writeReg,
    input  logic [31:0]          mem_aluResult,
    input  logic [31:0]          mem_readData,
    input  logic [31:0]          mem_pcPlus4,
    output logic                 regWrite,
    output logic [4:0]           writeReg,
    output logic [31:0]          writeData,
    output logic                 wb_valid,
    output logic                 misaligned,
    output logic [CNT_WIDTH-1:0] retired
);

    typedef struct packed {
        logic        valid;
        logic        reg_write;
        logic        mem_to_reg;
        logic        link;
        logic [1:0]  load_size;
        logic        load_unsigned;
        logic [4:0]  write_reg;
        logic [31:0] alu_result;
        logic [31:0] read_data;
        logic [31:0] pc_plus4;
    } wb_t;

    wb_t                 wb;
    wb_t                 mem_in;
    logic [CNT_WIDTH-1:0] cnt;

    always_comb begin
        mem_in               = '0;
        mem_in.valid         = mem_valid;
        mem_in.reg_write     = mem_regWrite;
        mem_in.mem_to_reg    = mem_memToReg;
        mem_in.link          = mem_link;
        mem_in.load_size     = mem_loadSize;
        mem_in.load_unsigned = mem_loadUnsigned;
        mem_in.write_reg     = mem_writeReg;
        mem_in.alu_result    = mem_aluResult;
        mem_in.read_data     = mem_readData;
        mem_in.pc_plus4      = mem_pcPlus4;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb <= '0;
        end else if (flush) begin
            wb <= '0;
        end else if (!stall) begin
            wb <= mem_in;
        end
    end

    // The outgoing entry completes whenever it leaves WB, even if the
    // slot behind it is being flushed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (wb.valid && !stall) begin
            cnt <= cnt + CNT_WIDTH'(1);
        end
    end

    logic [1:0]  lane;
    logic [1:0]  byte_sel;
    logic        half_sel;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] load_v;
    logic        is_half;
    logic        is_word;

    always_comb begin
        lane     = wb.alu_result[1:0];
        // Big-endian lane 0 lives in the top byte, so invert the index.
        byte_sel = BIG_ENDIAN ? ~lane : lane;
        half_sel = BIG_ENDIAN ? ~lane[1] : lane[1];
        byte_v   = wb.read_data[{byte_sel, 3'b000} +: 8];
        half_v   = wb.read_data[{half_sel, 4'b0000} +: 16];
        is_half  = (wb.load_size == 2'b01);
        is_word  = (wb.load_size[1] == wb.load_size[0]);
        load_v   = wb.read_data;
        unique case (wb.load_size)
            2'b10: begin
                load_v = {{24{byte_v[7] & ~wb.load_unsigned}}, byte_v};
            end
            2'b01: begin
                load_v = {{16{half_v[15] & ~wb.load_unsigned}}, half_v};
            end
            default: begin
                load_v = wb.read_data;
            end
        endcase
    end

    always_comb begin
        writeData = wb.alu_result;
        priority case (1'b1)
            wb.link:       writeData = wb.pc_plus4;
            wb.mem_to_reg: writeData = load_v;
            default:       writeData = wb.alu_result;
        endcase
    end

    always_comb begin
        misaligned = wb.valid & wb.mem_to_reg &
                     ((is_half & lane[0]) | (is_word & (lane != 2'b00)));
        regWrite   = wb.valid & wb.reg_write &
                     (wb.write_reg != 5'd0) & ~misaligned;
        writeReg   = wb.write_reg;
        wb_valid   = wb.valid;
        retired    = cnt;
    end

endmodule

// File: tb/tb_mem_wb_writeback.sv
// Self-checking bench for mem_wb_writeback: table-driven vectors with a
// scoreboard queue, plus reset, stall/flush and counter-wrap sequences.
module tb_mem_wb_writeback;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        flush;
    logic        mem_valid;
    logic        mem_regWrite;
    logic        mem_memToReg;
    logic        mem_link;
    logic [1:0]  mem_loadSize;
    logic        mem_loadUnsigned;
    logic [4:0]  mem_writeReg;
    logic [31:0] mem_aluResult;
    logic [31:0] mem_readData;
    logic [31:0] mem_pcPlus4;

    logic        regWrite;
    logic [4:0]  writeReg;
    logic [31:0] writeData;
    logic        wb_valid;
    logic        misaligned;
    logic [31:0] retired;

    logic        regWrite4;
    logic [4:0]  writeReg4;
    logic [31:0] writeData4;
    logic        wb_valid4;
    logic        misaligned4;
    logic [3:0]  retired4;

    always #5 clk = ~clk;

    mem_wb_writeback #(.CNT_WIDTH(32), .BIG_ENDIAN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .mem_valid(mem_valid), .mem_regWrite(mem_regWrite),
        .mem_memToReg(mem_memToReg), .mem_link(mem_link),
        .mem_loadSize(mem_loadSize), .mem_loadUnsigned(mem_loadUnsigned),
        .mem_writeReg(mem_writeReg), .mem_aluResult(mem_aluResult),
        .mem_readData(mem_readData), .mem_pcPlus4(mem_pcPlus4),
        .regWrite(regWrite), .writeReg(writeReg), .writeData(writeData),
        .wb_valid(wb_valid), .misaligned(misaligned), .retired(retired)
    );

    mem_wb_writeback #(.CNT_WIDTH(4), .BIG_ENDIAN(1'b0)) dut4 (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .mem_valid(mem_valid), .mem_regWrite(mem_regWrite),
        .mem_memToReg(mem_memToReg), .mem_link(mem_link),
        .mem_loadSize(mem_loadSize), .mem_loadUnsigned(mem_loadUnsigned),
        .mem_writeReg(mem_writeReg), .mem_aluResult(mem_aluResult),
        .mem_readData(mem_readData), .mem_pcPlus4(mem_pcPlus4),
        .regWrite(regWrite4), .writeReg(writeReg4), .writeData(writeData4),
        .wb_valid(wb_valid4), .misaligned(misaligned4), .retired(retired4)
    );

    typedef struct {
        string       name;
        logic        valid;
        logic        rw;
        logic        m2r;
        logic        link;
        logic [1:0]  sz;
        logic        uns;
        logic [4:0]  wr;
        logic [31:0] alu;
        logic [31:0] rd;
        logic [31:0] pc;
        logic        e_rw;
        logic [31:0] e_data;
        logic [31:0] e_data_le;
        logic        e_mis;
    } vec_t;

    typedef struct {
        string       name;
        logic        valid;
        logic        rw;
        logic [4:0]  wr;
        logic [31:0] data;
        logic [31:0] data_le;
        logic        mis;
    } exp_t;

    exp_t        sb[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_ret = 0;
    logic        cur_valid = 1'b0;
    vec_t        tv[$];

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", nm, act, req);
        end
    endfunction

    function automatic vec_t mk(string nm, logic v, logic rw, logic m2r,
                                logic lk, logic [1:0] sz, logic uns,
                                logic [4:0] wr, logic [31:0] alu,
                                logic [31:0] rd, logic [31:0] pc,
                                logic e_rw, logic [31:0] e_d,
                                logic [31:0] e_dle, logic e_mis);
        vec_t r;
        r.name = nm; r.valid = v; r.rw = rw; r.m2r = m2r; r.link = lk;
        r.sz = sz; r.uns = uns; r.wr = wr; r.alu = alu; r.rd = rd;
        r.pc = pc; r.e_rw = e_rw; r.e_data = e_d; r.e_data_le = e_dle;
        r.e_mis = e_mis;
        return r;
    endfunction

    function automatic exp_t to_exp(vec_t v);
        exp_t e;
        e.name = v.name; e.valid = v.valid; e.rw = v.e_rw; e.wr = v.wr;
        e.data = v.e_data; e.data_le = v.e_data_le; e.mis = v.e_mis;
        return e;
    endfunction

    task automatic drive(vec_t v);
        mem_valid        = v.valid;
        mem_regWrite     = v.rw;
        mem_memToReg     = v.m2r;
        mem_link         = v.link;
        mem_loadSize     = v.sz;
        mem_loadUnsigned = v.uns;
        mem_writeReg     = v.wr;
        mem_aluResult    = v.alu;
        mem_readData     = v.rd;
        mem_pcPlus4      = v.pc;
    endtask

    task automatic step();
        if (rst_n) begin
            if (cur_valid && !stall) exp_ret = exp_ret + 1;
            if (flush) cur_valid = 1'b0;
            else if (!stall) cur_valid = mem_valid;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check(exp_t e);
        chk({e.name, ".wb_valid"}, 32'(wb_valid), 32'(e.valid));
        chk({e.name, ".regWrite"}, 32'(regWrite), 32'(e.rw));
        chk({e.name, ".writeReg"}, 32'(writeReg), 32'(e.wr));
        chk({e.name, ".writeData"}, writeData, e.data);
        chk({e.name, ".misaligned"}, 32'(misaligned), 32'(e.mis));
        chk({e.name, ".retired"}, retired, exp_ret);
        chk({e.name, ".writeData_le"}, writeData4, e.data_le);
        chk({e.name, ".retired4"}, 32'(retired4), 32'(exp_ret[3:0]));
    endtask

    task automatic run_vec(vec_t v);
        exp_t e;
        drive(v);
        sb.push_back(to_exp(v));
        step();
        if (sb.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL %s: scoreboard empty", v.name);
        end else begin
            e = sb.pop_front();
            check(e);
        end
    endtask

    localparam logic [31:0] RD = 32'h80FF_7F01;

    vec_t idle;
    vec_t hold;
    vec_t junk;
    exp_t ze;

    initial begin
        rst_n = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        idle = mk("idle", 0, 0, 0, 0, 2'b00, 0, 5'd0, 32'h0, 32'h0, 32'h0,
                  0, 32'h0, 32'h0, 0);
        drive(idle);
        ze = to_exp(idle);

        tv.push_back(mk("add8", 1, 1, 0, 0, 2'b00, 0, 5'd8, 32'h5, RD, 32'h0,
                        1, 32'h5, 32'h5, 0));
        tv.push_back(mk("add0", 1, 1, 0, 0, 2'b00, 0, 5'd0, 32'h5, RD, 32'h0,
                        0, 32'h5, 32'h5, 0));
        tv.push_back(mk("lb1", 1, 1, 1, 0, 2'b10, 0, 5'd9, 32'h1, RD, 32'h0,
                        1, 32'hFFFF_FFFF, 32'h0000_007F, 0));
        tv.push_back(mk("lbu3", 1, 1, 1, 0, 2'b10, 1, 5'd9, 32'h3, RD, 32'h0,
                        1, 32'h0000_0001, 32'h0000_0080, 0));
        tv.push_back(mk("lb0", 1, 1, 1, 0, 2'b10, 0, 5'd9, 32'h0, RD, 32'h0,
                        1, 32'hFFFF_FF80, 32'h0000_0001, 0));
        tv.push_back(mk("lh2", 1, 1, 1, 0, 2'b01, 0, 5'd10, 32'h2, RD, 32'h0,
                        1, 32'h0000_7F01, 32'hFFFF_80FF, 0));
        tv.push_back(mk("lhu0", 1, 1, 1, 0, 2'b01, 1, 5'd10, 32'h0, RD, 32'h0,
                        1, 32'h0000_80FF, 32'h0000_7F01, 0));
        tv.push_back(mk("lh1001", 1, 1, 1, 0, 2'b01, 0, 5'd11, 32'h1001, RD,
                        32'h0, 0, 32'hFFFF_80FF, 32'h0000_7F01, 1));
        tv.push_back(mk("lw1002", 1, 1, 1, 0, 2'b00, 0, 5'd11, 32'h1002, RD,
                        32'h0, 0, RD, RD, 1));
        tv.push_back(mk("lw11", 1, 1, 1, 0, 2'b11, 0, 5'd12, 32'h1004, RD,
                        32'h0, 1, RD, RD, 0));
        tv.push_back(mk("jal", 1, 1, 1, 1, 2'b00, 0, 5'd31, 32'h0, RD,
                        32'h0040_0008, 1, 32'h0040_0008, 32'h0040_0008, 0));
        tv.push_back(mk("bubble", 0, 1, 0, 0, 2'b00, 0, 5'd5, 32'h77, RD,
                        32'h0, 0, 32'h77, 32'h77, 0));

        #3;
        ze.name = "reset";
        check(ze);
        #9;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_vec(tv[0]);
        run_vec(tv[0]);
        chk("pre_reset.retired", retired, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        exp_ret   = 0;
        cur_valid = 1'b0;
        ze.name = "mid_reset";
        check(ze);
        drive(idle);
        step();
        ze.name = "reset_held";
        check(ze);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (tv[i]) run_vec(tv[i]);

        hold = mk("hold", 1, 1, 0, 0, 2'b00, 0, 5'd10, 32'h1234, 32'h0, 32'h0,
                  1, 32'h1234, 32'h1234, 0);
        junk = mk("junk", 1, 1, 1, 1, 2'b10, 1, 5'd3, 32'hDEAD, RD, 32'hBEEF,
                  1, 32'h0, 32'h0, 0);
        run_vec(hold);
        drive(junk);
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            sb.push_back(to_exp(hold));
            step();
            check(sb.pop_front());
        end
        flush = 1'b1;
        sb.push_back(ze);
        sb[$].name = "flush_stall";
        step();
        check(sb.pop_front());
        stall = 1'b0;
        flush = 1'b0;

        run_vec(hold);
        flush = 1'b1;
        sb.push_back(ze);
        sb[$].name = "flush_retire";
        step();
        check(sb.pop_front());
        flush = 1'b0;

        for (int k = 0; k < 18; k++) begin
            hold.name = $sformatf("wrap%0d", k);
            hold.alu  = 32'(k);
            hold.e_data = 32'(k);
            hold.e_data_le = 32'(k);
            run_vec(hold);
        end
        run_vec(idle);
        chk("final.retired", retired, exp_ret);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
